// File: rtl/serial_adder_subtractor.sv
// serial_adder_subtractor: bit-serial LSB-first add/subtract behind a start/done handshake
module serial_adder_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S_D,
    output logic             C_B_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
    logic             carry, s, c_nxt, last;
    logic [CW-1:0]    cnt;

    assign s       = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nxt   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign res_nxt = (res_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign last    = cnt == CW'(WIDTH - 1);
    assign busy    = state == SHIFT;
    assign done    = state == DONE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: DONE lasts one cycle and always returns to IDLE
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE)  ? (start ? SHIFT : IDLE) :
                    (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

    // datapath: subtraction pre-inverts B and seeds the carry with 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            S_D     <= '0;
            C_B_out <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr  <= A;
            b_sr  <= B ^ {WIDTH{Mode}};
            carry <= Mode;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            carry  <= c_nxt;
            cnt    <= cnt + 1'b1;
            if (last) begin
                S_D     <= res_nxt;
                C_B_out <= c_nxt;
            end
        end
    end
endmodule
